instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the dual-slot control/decode stage. Keeps the PC and issues single-outstanding

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request channel, decode-side IR handshake
// and the redirect controls fed back from the dual-slot decode stage.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              ir_valid;
  logic              ir_ready;
  logic [31:0]       IR;
  logic [ADDR_W-1:0] ir_pc;
  logic [1:0]        PcSrc;
  logic              branch;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;

  modport master (
    output imem_req, imem_addr, ir_valid, IR, ir_pc,
    input  imem_ack, imem_rdata, ir_ready, PcSrc, branch, br_taken, br_target, jmp_target
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, IR, ir_pc,
    output imem_ack, imem_rdata, ir_ready, PcSrc, branch, br_taken, br_target, jmp_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem reads, prefetch FIFO, branch/jump redirect.
// Optional `NOP_SKIP_EN: double-nop words (IR[4:0]==0 && IR[20:16]==0) are not buffered.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

  logic              is_jump;
  logic              redirect;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              ack_fetch;
  logic              keep_word;
  logic              push;
  logic              pop;
  logic              ir_valid;

  assign is_jump    = (bus.PcSrc == 2'b10);
  assign redirect   = is_jump | ((bus.PcSrc == 2'b01) & bus.branch & bus.br_taken);
  assign target_raw = is_jump ? bus.jmp_target : bus.br_target;
  assign target     = target_raw & ~ADDR_W'(3);
  assign pc_inc     = pc_q + ADDR_W'(4);

`ifdef NOP_SKIP_EN
  assign keep_word = (bus.imem_rdata[4:0] != 5'd0) | (bus.imem_rdata[20:16] != 5'd0);
`else
  assign keep_word = 1'b1;
`endif

  assign ir_valid  = (count_q != '0);
  assign ack_fetch = (state_q == REQ) & bus.imem_ack;
  assign push      = ack_fetch & ~redirect & keep_word;
  assign pop       = ir_valid & bus.ir_ready & ~redirect;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (redirect) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pc_q     <= target;
      if (state_q != IDLE && !bus.imem_ack) begin
        state_q <= DROP;
      end else begin
        // Bus is free after this edge, so the target fetch issues immediately.
        state_q <= REQ;
        req_q   <= 1'b1;
        addr_q  <= target;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (count_q < DEPTH_C) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            pc_q <= pc_inc;
            if (count_d < DEPTH_C) begin
              addr_q <= pc_inc;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.ir_valid  = ir_valid;
  assign bus.IR        = ir_valid ? data_mem[rd_ptr_q] : '0;
  assign bus.ir_pc     = ir_valid ? pc_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: redirect decode table plus directed
// sequences for drop, flush-on-ack, full-FIFO pop+push, PC wrap and nop words.
module tb_instr_fetch_unit;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

  instr_fetch_unit #(
    .ADDR_W    (AW),
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned lat;
  int unsigned wcnt;
  logic        zero_en;
  logic [31:0] zero_addr;
  int          ack_cnt;
  int          checks;
  int          errors;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return (zero_en && a == zero_addr) ? 32'h0 : word_of(a);
  endfunction

  // Instruction memory: acks after `lat` waiting cycles of a held request.
  assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata = (zero_en && bus.imem_addr == zero_addr) ? 32'h0 : word_of(bus.imem_addr);

  always @(posedge clk) begin
    if (reset || !bus.imem_req || bus.imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!reset && bus.imem_req && bus.imem_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clear_ctl();
    bus.PcSrc      = 2'b00;
    bus.branch     = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;
    bus.jmp_target = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ir_ready = 1'b0;
    zero_en = 1'b0;
    clear_ctl();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Checks the head, then lets the pop edge pass (ir_ready must be 1).
  task automatic expect_pop(input string nm, input logic [31:0] epc);
    int n = 0;
    while (!bus.ir_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ir_valid) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_pc"}, bus.ir_pc, epc);
      chk({nm, "_ir"}, bus.IR, exp_word(epc));
    end
    @(negedge clk);
  endtask

  task automatic wait_req(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.imem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]  pcsrc;
    logic        br;
    logic        tk;
    logic        rdy;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic        bad_valid;
    int          n;
    int          a0;

    checks = 0; errors = 0; ack_cnt = 0;
    lat = 1; zero_en = 1'b0; zero_addr = '0;
    reset = 1'b1;
    bus.ir_ready = 1'b0;
    clear_ctl();

    //           pcsrc br  tk  rdy  btgt          jtgt          valid pc     req  addr
    tbl[0]  = '{2'b00, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0, 0, 32'h0};
    tbl[1]  = '{2'b00, 0, 0, 1, 32'h0,        32'h0,        1, 32'h4, 1, 32'h10};
    tbl[2]  = '{2'b11, 1, 1, 0, 32'h80,       32'h90,       1, 32'h0, 0, 32'h0};
    tbl[3]  = '{2'b01, 1, 0, 1, 32'h80,       32'h0,        1, 32'h4, 1, 32'h10};
    tbl[4]  = '{2'b01, 0, 1, 0, 32'h80,       32'h0,        1, 32'h0, 0, 32'h0};
    tbl[5]  = '{2'b01, 1, 1, 0, 32'h203,      32'h0,        0, 32'h0, 1, 32'h200};
    tbl[6]  = '{2'b10, 0, 0, 0, 32'h0,        32'h1002,     0, 32'h0, 1, 32'h1000};
    tbl[7]  = '{2'b10, 1, 1, 0, 32'h500,      32'h777,      0, 32'h0, 1, 32'h774};
    tbl[8]  = '{2'b01, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        0, 32'h0, 1, 32'hFFFFFFFC};
    tbl[9]  = '{2'b11, 1, 1, 1, 32'h80,       32'h90,       1, 32'h4, 1, 32'h10};
    tbl[10] = '{2'b00, 1, 1, 1, 32'h80,       32'h0,        1, 32'h4, 1, 32'h10};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("rst_ir", bus.IR, 32'h0);
    chk("rst_irpc", bus.ir_pc, 32'h0);

    // 1: sequential stream
    do_reset();
    lat = 1;
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_pop($sformatf("seq%0d", i), 32'(i * 4));

    // 2: backpressure fills exactly four entries, then resumes at 0x10
    do_reset();
    a0 = ack_cnt;
    repeat (30) @(negedge clk);
    chk("full_acks", 32'(ack_cnt - a0), 32'd4);
    chk("full_req", {31'd0, bus.imem_req}, 32'd0);
    chk("full_head", bus.ir_pc, 32'h0);
    bus.ir_ready = 1'b1;
    expect_pop("bp0", 32'h0);
    bus.ir_ready = 1'b0;
    wait_req(seen);
    chk("bp_req_seen", {31'd0, seen}, 32'd1);
    chk("bp_req_addr", bus.imem_addr, 32'h10);
    repeat (10) @(negedge clk);
    bus.ir_ready = 1'b1;
    expect_pop("bp1", 32'h4);
    expect_pop("bp2", 32'h8);
    expect_pop("bp3", 32'hC);
    expect_pop("bp4", 32'h10);

    // 3: jump during an outstanding request, stale data dropped
    do_reset();
    lat = 3;
    bus.ir_ready = 1'b1;
    wait_req(seen);
    chk("drop_first_req", bus.imem_addr, 32'h0);
    bus.PcSrc = 2'b10;
    bus.jmp_target = 32'h103;
    @(negedge clk);
    clear_ctl();
    bad_valid = 1'b0;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr != 32'h0) && n < 20) begin
      if (bus.ir_valid) bad_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("drop_fifo_empty", {31'd0, bad_valid}, 32'd0);
    chk("drop_next_addr", bus.imem_addr, 32'h100);
    expect_pop("drop0", 32'h100);
    expect_pop("drop1", 32'h104);
    // Reset while a request is outstanding drops it
    wait_req(seen);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_mid_valid", {31'd0, bus.ir_valid}, 32'd0);

    // 4: taken branch in the same cycle as an ack and a ready head
    do_reset();
    lat = 0;
    bus.ir_ready = 1'b1;
    n = 0;
    while (!(bus.imem_ack && bus.ir_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("flush_setup", {30'd0, bus.imem_ack, bus.ir_valid}, 32'd3);
    bus.PcSrc = 2'b01;
    bus.branch = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 32'h41;
    @(negedge clk);
    clear_ctl();
    chk("flush_valid", {31'd0, bus.ir_valid}, 32'd0);
    wait_req(seen);
    chk("flush_req_addr", bus.imem_addr, 32'h40);
    expect_pop("flush0", 32'h40);
    expect_pop("flush1", 32'h44);

    // 5a: full FIFO, then pop coinciding with ack keeps the fetch going
    do_reset();
    lat = 1;
    repeat (30) @(negedge clk);
    lat = 2;
    bus.ir_ready = 1'b1;
    @(negedge clk);
    bus.ir_ready = 1'b0;
    n = 0;
    while (!bus.imem_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pp_ack_addr", bus.imem_addr, 32'h10);
    bus.ir_ready = 1'b1;
    @(negedge clk);
    bus.ir_ready = 1'b0;
    chk("pp_reissue", {31'd0, bus.imem_req}, 32'd1);
    chk("pp_next_addr", bus.imem_addr, 32'h14);
    chk("pp_head", bus.ir_pc, 32'h8);
    repeat (20) @(negedge clk);
    chk("pp_full_req", {31'd0, bus.imem_req}, 32'd0);
    bus.ir_ready = 1'b1;
    expect_pop("pp0", 32'h8);
    expect_pop("pp1", 32'hC);
    expect_pop("pp2", 32'h10);
    expect_pop("pp3", 32'h14);

    // 5b: PC wraps past the top of the address space
    do_reset();
    lat = 1;
    bus.ir_ready = 1'b1;
    bus.PcSrc = 2'b10;
    bus.jmp_target = 32'hFFFFFFFC;
    @(negedge clk);
    clear_ctl();
    expect_pop("wrap0", 32'hFFFFFFFC);
    expect_pop("wrap1", 32'h0);
    expect_pop("wrap2", 32'h4);

    // 6: all-zero word at address 8
    do_reset();
    lat = 1;
    zero_en = 1'b1;
    zero_addr = 32'h8;
    bus.ir_ready = 1'b1;
    expect_pop("nop0", 32'h0);
    expect_pop("nop1", 32'h4);
`ifndef NOP_SKIP_EN
    expect_pop("nop2", 32'h8);
`endif
    expect_pop("nop3", 32'hC);

    // Redirect decode table, each vector applied to a freshly filled FIFO
    for (int i = 0; i < 11; i++) begin
      do_reset();
      lat = 1;
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_pre", i), {bus.ir_pc[29:0], bus.ir_valid, bus.imem_req}, 32'd2);
      bus.PcSrc      = tbl[i].pcsrc;
      bus.branch     = tbl[i].br;
      bus.br_taken   = tbl[i].tk;
      bus.br_target  = tbl[i].btgt;
      bus.jmp_target = tbl[i].jtgt;
      bus.ir_ready   = tbl[i].rdy;
      @(negedge clk);
      clear_ctl();
      bus.ir_ready = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.ir_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk($sformatf("v%0d_pc", i), bus.ir_pc, tbl[i].e_pc);
      wait_req(seen);
      chk($sformatf("v%0d_req", i), {31'd0, seen}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
